nois_system_led_ctrl: RTL and testbench
=======================================

# nois_system_led_ctrl

Parametrised Avalon-MM LED/PIO output controller that generalises the single-register LED port to WIDTH channels. It adds atomic set/clear registers, per-channel static or PWM mode with a shared duty cycle, and optional frame-based blinking. It sits on the Nios system interconnect as a zero-wait-state slave and drives board LEDs through `out_port`.

## Interface
- `WIDTH`, 8: number of output channels, 1..32.
- `PWM_BITS`, 8: PWM counter/duty width, 2..16.
- `PRESCALE`, 50: clk cycles per PWM tick, ≥1.
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: word register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` in 32: write data; bits above the register width are ignored.
- `readdata` out 32: combinational read data, zero-extended.
- `out_port` out WIDTH: registered LED drive.

## Operation
- Register map (word addresses):
  - 0 DATA (R/W, WIDTH): channel level/enable.
  - 1 MODE (R/W, WIDTH): per channel, 0 = static, 1 = PWM.
  - 2 DUTY (R/W, PWM_BITS): shared duty.
  - 3 BLINK (R/W, 16): blink half-period in PWM frames.
  - 4 OUTSET (W): DATA |= wd.
  - 5 OUTCLEAR (W): DATA &= ~wd.
  - 6 STATUS (R): bit0 = blink_phase; bits[PWM_BITS+15:16] = pwm_cnt.
  - 7: reserved.
- Reads of 4, 5 and 7 return 0. Writes to 6 and 7 are ignored.
- Reset values: DATA, MODE, DUTY and BLINK = 0; active_duty = 0; blink_phase = 1; all counters = 0; `out_port` = 0.
- Prescaler: counts 0..PRESCALE-1 and pulses `tick` at PRESCALE-1, then wraps to 0. With PRESCALE=1, `tick` is asserted every cycle.
- PWM counter:
  - `pwm_cnt` increments on `tick` and wraps from 2^PWM_BITS-1 to 0.
  - `frame_end` = tick && pwm_cnt == all-ones.
- Duty shadow: active_duty loads DUTY on `frame_end`.
  - pwm_on = pwm_cnt < active_duty, unsigned compare.
  - Duty 0 gives always off; all-ones gives on (2^PWM_BITS-1)/2^PWM_BITS of the time.
- Blink:
  - On `frame_end` with BLINK≠0, blink_cnt increments. When it reaches BLINK-1, it clears and blink_phase toggles.
  - BLINK=0 forces blink_phase = 1 and holds blink_cnt at 0.
  - Any write to BLINK clears blink_cnt and sets blink_phase = 1 on the same edge.
- Output, per channel i, registered: `out_port[i]` <= MODE[i] ? (DATA[i] & pwm_on & blink_phase) : DATA[i].

## Timing
- Reads: zero wait state. `readdata` is valid in the same cycle as `address`/`chipselect`.
- Writes: the register updates at the write edge. `out_port` reflects the change one clock later.
  - Example: an OUTSET write at edge N updates DATA at N and `out_port` at N+1.
- DUTY write coinciding with `frame_end`: active_duty loads the pre-write DUTY value. The new value takes effect at the next frame.
- BLINK write coinciding with a toggle condition: the write wins (blink_cnt = 0, blink_phase = 1).
- Reset asserted mid-frame: all state returns to reset values immediately. After release, counting restarts from 0.
- Counters run continuously, independent of bus activity.

## Configuration
- `NOIS_LED_CTRL_BLINK_EN` defined: BLINK register, blink_cnt and blink_phase are implemented as described.
- Not defined:
  - The blink logic is removed; blink_phase is constant 1.
  - Address 3 reads 0 and ignores writes.
  - STATUS bit0 reads 1.

## Structure
- Shared package `nois_led_pkg`: register address constants (ADDR_DATA..ADDR_STATUS) and the BLINK width constant (16).
- One sub-module, `nois_led_pwm_timebase`: prescaler, pwm_cnt, `tick`/`frame_end` generation, and the active_duty shadow. It outputs `pwm_on`, `frame_end` and `pwm_cnt`.
- The top level holds the register file, read mux, blink logic and output register.

## Test plan
Bench parameters: WIDTH=8, PWM_BITS=4, PRESCALE=2.
- Reset: hold reset_n=0 mid-run -> `out_port`=0x00, STATUS=0x1; after release, pwm_cnt restarts at 0.
- Static and atomic writes: write DATA=0xA5 -> `out_port`=0xA5 one cycle later. Then OUTSET 0x0F -> 0xAF; OUTCLEAR 0xA0 -> 0x0F. Reads of 4 and 5 return 0.
- PWM: DATA=0xFF, MODE=0x01, DUTY=4 -> bit0 high for exactly 8 of every 32 clocks after the next frame boundary; bits7:1 remain steady 1.
- Duty at boundary: write DUTY=8 on the `frame_end` cycle -> that frame still uses the old duty; 16/32 high from the following frame.
- Blink: BLINK=2, DUTY=15, MODE=0x01 -> bit0 PWM-active for 2 frames (64 clocks), off for 2 frames, repeating. Rewriting BLINK mid-off-phase restores phase=1 immediately.
- Macro off: build without `NOIS_LED_CTRL_BLINK_EN`; write BLINK=2 -> address 3 reads 0, and the output never blinks.

Source files
------------

// File: rtl/nois_led_pkg.sv
// nois_led_pkg: shared register map and field widths for the LED controller.
package nois_led_pkg;

    // Word addresses of the slave register map.
    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_MODE     = 3'd1,
        ADDR_DUTY     = 3'd2,
        ADDR_BLINK    = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLEAR = 3'd5,
        ADDR_STATUS   = 3'd6,
        ADDR_RSVD     = 3'd7
    } led_addr_e;

    // Width of the BLINK half-period register and its frame counter.
    localparam int BLINK_W = 16;

endpackage

// File: rtl/nois_led_pwm_timebase.sv
// nois_led_pwm_timebase: prescaler, free-running PWM counter, frame_end
// strobe and the frame-synchronous duty shadow that produces pwm_on.
module nois_led_pwm_timebase #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_on,
    output logic                o_frame_end,
    output logic [PWM_BITS-1:0] o_pwm_cnt
);
    // PRESCALE=1 still needs a 1-bit counter; it simply stays at 0 and ticks every cycle.
    localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_active_duty;
    logic                w_tick;
    logic                w_frame_end;

    assign w_tick      = (r_pre == PRE_MAX);
    assign w_frame_end = w_tick && (&r_pwm_cnt);

    // Prescaler: count 0..PRESCALE-1, tick on the last count and wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // PWM counter: advances once per tick and wraps naturally at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // Duty shadow: take the register value only at a frame boundary so a frame never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active_duty <= '0;
        end else if (w_frame_end) begin
            r_active_duty <= i_duty;
        end
    end

    assign o_pwm_on    = (r_pwm_cnt < r_active_duty);
    assign o_frame_end = w_frame_end;
    assign o_pwm_cnt   = r_pwm_cnt;

endmodule

// File: rtl/nois_system_led_ctrl.sv
// nois_system_led_ctrl: zero-wait-state Avalon-MM LED/PIO controller with
// atomic set/clear, per-channel static/PWM mode and a shared duty cycle.
// Optional feature macro: NOIS_LED_CTRL_BLINK_EN adds the BLINK register and
// frame-based blinking; without it blink_phase is constant 1.
module nois_system_led_ctrl
    import nois_led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    led_addr_e           w_addr;
    logic                w_wr;
    logic [WIDTH-1:0]    w_wd_ch;
    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mode;
    logic [WIDTH-1:0]    r_out;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_pwm_on;
    logic                w_frame_end;
    logic                w_blink_phase;
    logic [BLINK_W-1:0]  w_blink_rd;
    logic                w_unused_bits;

    assign w_addr  = led_addr_e'(address);
    assign w_wr    = chipselect && !write_n;
    assign w_wd_ch = writedata[WIDTH-1:0];
    // Upper write-data bits are ignored; frame_end is idle when blinking is compiled out.
    assign w_unused_bits = ^{writedata, w_frame_end};

    nois_led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_duty      (r_duty),
        .o_pwm_on    (w_pwm_on),
        .o_frame_end (w_frame_end),
        .o_pwm_cnt   (w_pwm_cnt)
    );

    // Register file: DATA with atomic set/clear aliases, MODE and shared DUTY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_mode <= '0;
            r_duty <= '0;
        end else if (w_wr) begin
            case (w_addr)
                ADDR_DATA:     r_data <= w_wd_ch;
                ADDR_MODE:     r_mode <= w_wd_ch;
                ADDR_DUTY:     r_duty <= writedata[PWM_BITS-1:0];
                ADDR_OUTSET:   r_data <= r_data | w_wd_ch;
                ADDR_OUTCLEAR: r_data <= r_data & ~w_wd_ch;
                default:       ;
            endcase
        end
    end

`ifdef NOIS_LED_CTRL_BLINK_EN
    logic [BLINK_W-1:0] r_blink;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic               w_blink_wr;

    assign w_blink_wr = w_wr && (w_addr == ADDR_BLINK);

    // BLINK half-period register (in PWM frames).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink <= '0;
        end else if (w_blink_wr) begin
            r_blink <= writedata[BLINK_W-1:0];
        end
    end

    // Blink phase: a BLINK write restarts the visible phase and beats a coincident toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_blink_wr || (r_blink == '0)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == r_blink - BLINK_W'(1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign w_blink_phase = r_blink_phase;
    assign w_blink_rd    = r_blink;
`else
    assign w_blink_phase = 1'b1;
    assign w_blink_rd    = '0;
`endif

    // Read mux: combinational, zero-extended; write-only and reserved words read 0.
    always_comb begin
        readdata = '0;
        case (w_addr)
            ADDR_DATA:   readdata[WIDTH-1:0]    = r_data;
            ADDR_MODE:   readdata[WIDTH-1:0]    = r_mode;
            ADDR_DUTY:   readdata[PWM_BITS-1:0] = r_duty;
            ADDR_BLINK:  readdata[BLINK_W-1:0]  = w_blink_rd;
            ADDR_STATUS: begin
                readdata[0]               = w_blink_phase;
                readdata[PWM_BITS+15:16]  = w_pwm_cnt;
            end
            default:     ;
        endcase
    end

    // Output register: PWM channels gated by pwm_on and blink phase, static channels follow DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else begin
            r_out <= (r_data & ~r_mode)
                   | (r_data & r_mode & {WIDTH{w_pwm_on & w_blink_phase}});
        end
    end

    assign out_port = r_out;

endmodule

// File: tb/tb_nois_system_led_ctrl.sv
// tb_nois_system_led_ctrl: directed plus randomized bench for the LED controller.
// The reference model derives counter state from the cycle count since reset
// and blink phase from the number of frames since the last BLINK write.
`timescale 1ns/1ps
module tb_nois_system_led_ctrl;
    localparam int WIDTH    = 8;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int NCNT     = 1 << PWM_BITS;
    localparam int FRAME    = PRESCALE * NCNT;
    localparam int unsigned MASK = (1 << WIDTH) - 1;
`ifdef NOIS_LED_CTRL_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [2:0]       address = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_k;
    int unsigned m_data, m_mode, m_duty, m_blink, m_active, m_nfe, m_out;

    always #5 clk = ~clk;

    nois_system_led_ctrl #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    function automatic int m_cnt();
        return (m_k / PRESCALE) % NCNT;
    endfunction

    function automatic bit m_phase();
        if (m_blink == 0) return 1'b1;
        return ((m_nfe / m_blink) % 2) == 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model across the edge, then compare out_port.
    task automatic step();
        bit          fe, on, wr;
        int unsigned on_mask;
        @(posedge clk);
        fe      = (m_k % FRAME) == (FRAME - 1);
        on      = m_cnt() < int'(m_active);
        on_mask = (on && m_phase()) ? MASK : 0;
        m_out   = (m_data & ~m_mode & MASK) | (m_data & m_mode & on_mask);
        wr      = chipselect && !write_n;
        if (fe) begin
            m_active = m_duty;
            m_nfe++;
        end
        if (wr) begin
            case (int'(address))
                0: m_data = writedata & MASK;
                1: m_mode = writedata & MASK;
                2: m_duty = writedata & (NCNT - 1);
                3: if (BLINK_EN) begin
                       m_blink = writedata & 32'hFFFF;
                       m_nfe   = 0;
                   end
                4: m_data = (m_data | writedata) & MASK;
                5: m_data = m_data & ~writedata & MASK;
                default: ;
            endcase
        end
        m_k++;
        #1;
        check("out_port_cycle", 32'(out_port), m_out);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        logic [31:0] exp;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        case (int'(a))
            0:       exp = m_data;
            1:       exp = m_mode;
            2:       exp = m_duty;
            3:       exp = BLINK_EN ? m_blink : 32'd0;
            6:       exp = 32'((m_cnt() << 16) | int'(m_phase()));
            default: exp = 32'd0;
        endcase
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_k = 0; m_data = 0; m_mode = 0; m_duty = 0; m_blink = 0;
        m_active = 0; m_nfe = 0; m_out = 0;
        check("reset_out_port", 32'(out_port), 32'h0);
        address = 3'd6;
        #1;
        check("reset_status", readdata, 32'h1);
        address = 3'd0;
        #1;
        check("reset_data", readdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int hi;
        int guard;
        logic [2:0] ra;

        #3;
        do_reset();

        // Static and atomic writes
        wr(3'd0, 32'hFFFF_FFA5);
        step();
        check("static_A5", 32'(out_port), 32'hA5);
        wr(3'd4, 32'h0F);
        step();
        check("outset_AF", 32'(out_port), 32'hAF);
        wr(3'd5, 32'hA0);
        step();
        check("outclear_0F", 32'(out_port), 32'h0F);
        rd(3'd4, "read_outset");
        rd(3'd5, "read_outclear");
        rd(3'd7, "read_rsvd");
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0, "read_data_0F");
        rd(3'd6, "read_status");

        // PWM with duty 4: bit0 high 8 of 32 clocks, bits 7:1 steady
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h4);
        repeat (FRAME + 2) step();
        hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            hi += int'(out_port[0]);
        end
        check("pwm_duty4_count", 32'(hi), 32'(4 * PRESCALE));
        check("pwm_static_bits", 32'(out_port[7:1]), 32'h7F);

        // DUTY write on the frame_end cycle: old duty for this frame, new duty after
        guard = 0;
        while ((m_k % FRAME) != (FRAME - 1) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        wr(3'd2, 32'h8);
        hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            hi += int'(out_port[0]);
        end
        check("duty_boundary_old", 32'(hi), 32'(4 * PRESCALE));
        hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            hi += int'(out_port[0]);
        end
        check("duty_boundary_new", 32'(hi), 32'(8 * PRESCALE));

        // Blink
        wr(3'd2, 32'hF);
        if (BLINK_EN) begin
            wr(3'd3, 32'h2);
            rd(3'd3, "blink_readback");
            rd(3'd6, "blink_status_on");
            guard = 0;
            while (m_phase() && guard < 8 * FRAME) begin
                step();
                guard++;
            end
            check("blink_reach_off", 32'(guard < 8 * FRAME), 32'h1);
            hi = 0;
            for (int i = 0; i < FRAME; i++) begin
                step();
                hi += int'(out_port[0]);
            end
            check("blink_off_count", 32'(hi), 32'h0);
            rd(3'd6, "blink_status_off");
            wr(3'd3, 32'h2);
            address = 3'd6;
            #1;
            check("blink_rewrite_phase", 32'(readdata[0]), 32'h1);
            repeat (6 * FRAME) step();
        end else begin
            repeat (FRAME + 2) step();
            wr(3'd3, 32'h2);
            rd(3'd3, "blink_off_read");
            hi = 0;
            for (int i = 0; i < 8 * FRAME; i++) begin
                step();
                hi += int'(out_port[0]);
            end
            check("noblink_count", 32'(hi), 32'(8 * 15 * PRESCALE));
            address = 3'd6;
            #1;
            check("noblink_status_bit0", 32'(readdata[0]), 32'h1);
        end

        // Mid-run reset with outputs active, then counting restarts from 0
        repeat (7) step();
        do_reset();
        step();
        step();
        address = 3'd6;
        #1;
        check("restart_cnt", 32'(readdata[31:16]), 32'h1);

        // Randomized bus traffic against the model
        for (int n = 0; n < 80; n++) begin
            ra = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: begin
                    if (ra == 3'd3) wr(ra, 32'($urandom_range(0, 3)));
                    else            wr(ra, $urandom);
                end
                1: rd(ra, "rand_read");
                default: begin
                    repeat ($urandom_range(1, 40)) step();
                end
            endcase
        end
        rd(3'd6, "final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
